riscv_pc_alu_dmem: RTL and testbench
====================================

RISCV_PC_ALU_DMEM -- requirements
Module: riscv_pc_alu_dmem

Interface
REQ-001 The block SHALL have parameter DMEM_WORDS, default 256, giving the number of 32-bit data-memory words (power of two).
REQ-002 The block SHALL have parameter PC_STEP, default 4, giving the per-cycle PC increment in bytes.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port finish_flag, input, 1 bit: when 1, the PC is frozen.
REQ-006 The block SHALL have port pc_reg, output, 32 bits: the current program counter (byte address).
REQ-007 The block SHALL have port ALUctl, input, 4 bits: the ALU operation select.
REQ-008 The block SHALL have ports A and B, input, 32 bits each: the ALU operands.
REQ-009 The block SHALL have port ALUout, output, 32 bits: the ALU result.
REQ-010 The block SHALL have port zero, output, 1 bit: 1 when ALUout equals 0.
REQ-011 The block SHALL have port write_enable, input, 1 bit: data-memory write strobe.
REQ-012 The block SHALL have port read_enable, input, 1 bit: data-memory read enable.
REQ-013 The block SHALL have port address, input, 32 bits: data-memory byte address.
REQ-014 The block SHALL have port write_data, input, 32 bits: the word to store.
REQ-015 The block SHALL have port read_data, output, 32 bits: the loaded word.

Function
REQ-016 On each rising clk edge with reset high and finish_flag low, pc_reg SHALL become pc_reg + PC_STEP, modulo 2^32 (0xFFFFFFFC + 4 -> 0).
REQ-017 On a rising clk edge with finish_flag high, pc_reg SHALL hold its value.
REQ-018 ALUout SHALL be combinational with no cycle latency, as follows:
- ALUctl 0: A AND B
- ALUctl 1: A OR B
- ALUctl 2: A + B, wrapping modulo 2^32, carry discarded
- ALUctl 6: A - B, wrapping modulo 2^32
- Any other code: 0, except as extended by REQ-028.
REQ-019 zero SHALL be combinational and SHALL equal (ALUout == 0) for every ALUctl code, including undefined codes.
REQ-020 The data-memory word index SHALL be address[log2(DMEM_WORDS)+1:2]; address[1:0] and the upper address bits SHALL be ignored, so out-of-range addresses wrap.
REQ-021 When write_enable is 1 on a rising clk edge, write_data SHALL be stored at the indexed word; there is no partial-word write.
REQ-022 read_data SHALL be combinational: it SHALL show the indexed word when read_enable is 1, and 0 when read_enable is 0.
REQ-023 When write_enable and read_enable are both 1 on the same address, read_data SHALL show the old word before the edge and the new word after it.
REQ-024 Data-memory contents SHALL power up as 0 (initial zero fill).

Reset
REQ-025 While reset is low, pc_reg SHALL be forced to 0 immediately, independent of clk.
REQ-026 Reset SHALL NOT clear data-memory contents and SHALL NOT affect the combinational ALU.
REQ-027 On reset deassertion, the first increment SHALL occur at the next rising clk edge, giving pc_reg = PC_STEP.

Configuration
REQ-028 With macro ALU_EXT_OPS_EN defined, the ALU SHALL additionally implement:
- ALUctl 7: signed set-less-than, result 1 or 0
- ALUctl 12: NOR of A and B.
Without ALU_EXT_OPS_EN, ALUctl codes 7 and 12 SHALL yield ALUout = 0 and zero = 1.

Verification
REQ-029 PC sequence: assert reset low, release, run 3 clocks with finish_flag=0 -> pc_reg reads 0, 4, 8, 12; set finish_flag=1 for 2 clocks -> pc_reg stays 12.
REQ-030 Async reset: with pc_reg=12, pull reset low mid-cycle -> pc_reg = 0 before the next clk edge.
REQ-031 Basic ALU ops -> required results:
- ALUctl=2, A=5, B=7 -> ALUout=12, zero=0
- ALUctl=6, A=7, B=7 -> ALUout=0, zero=1
- ALUctl=0, A=0xF0F0, B=0xFF00 -> ALUout=0xF000
- ALUctl=1 with the same operands -> ALUout=0xFFF0
REQ-032 ALU wrap and undefined code:
- ALUctl=2, A=0xFFFFFFFF, B=1 -> ALUout=0, zero=1
- ALUctl=5 -> ALUout=0, zero=1
REQ-033 Memory store/load: write 0xDEADBEEF at address 8, then read at address 8 (and at 9) with read_enable=1 -> read_data=0xDEADBEEF; read_enable=0 -> read_data=0.
REQ-034 Memory wrap: with DMEM_WORDS=256, a write of 0x1234 at address 1024 -> a read at address 0 returns 0x1234.

Source files
------------

// File: rtl/riscv_pc_alu_dmem.sv
// riscv_pc_alu_dmem: program counter, combinational ALU and word-addressed data memory
// for a single-cycle RISC-V style datapath.
//
// Optional feature macro: ALU_EXT_OPS_EN
//   defined   -> ALU also implements ALUctl 7 (signed set-less-than) and 12 (NOR)
//   undefined -> codes 7 and 12 fall through to the default result of 0
//
// The port named reset is an asynchronous, active-low reset. It clears only the PC.
// Memory contents and the ALU are not affected by it.

module riscv_pc_alu_dmem #(
    parameter int unsigned DMEM_WORDS = 256,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        finish_flag,
    output logic [31:0] pc_reg,
    input  logic [3:0]  ALUctl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] ALUout,
    output logic        zero,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int unsigned AW   = $clog2(DMEM_WORDS);
    localparam logic [31:0] STEP = 32'(PC_STEP);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
`ifdef ALU_EXT_OPS_EN
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;
`endif

    logic [31:0]   alu_result;
    logic [AW-1:0] word_idx;
    logic          unused_addr;

    // Power-up zero fill is done with a declaration initializer.
    // Reset does not clear this array.
    logic [31:0]   mem [DMEM_WORDS] = '{default: 32'h0};

    // PC register: the reset is asynchronous, the PC wraps modulo 2^32,
    // and finish_flag holds the current value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= 32'h0;
        end else if (!finish_flag) begin
            pc_reg <= pc_reg + STEP;
        end
    end

    // ALU operation decode. Any code not listed here gives 0.
    always_comb begin
        alu_result = 32'h0;
        case (ALUctl)
            OP_AND:  alu_result = A & B;
            OP_OR:   alu_result = A | B;
            OP_ADD:  alu_result = A + B;
            OP_SUB:  alu_result = A - B;
`ifdef ALU_EXT_OPS_EN
            OP_SLT:  alu_result = {31'h0, ($signed(A) < $signed(B))};
            OP_NOR:  alu_result = ~(A | B);
`endif
            default: alu_result = 32'h0;
        endcase
    end

    assign ALUout = alu_result;
    assign zero   = (alu_result == 32'h0);

    // The word index comes from address bits [AW+1:2]. The byte offset and the
    // upper bits are dropped, so an out-of-range address wraps onto the array.
    assign word_idx    = address[AW+1:2];
    assign unused_addr = ^{address[31:AW+2], address[1:0]};

    // Full-word store. There is no byte-lane masking.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[word_idx] <= write_data;
        end
    end

    // The read is asynchronous. If a write hits the same word, read_data shows
    // the old word until the clock edge and the new word after it.
    assign read_data = read_enable ? mem[word_idx] : 32'h0;

endmodule

// File: tb/tb_riscv_pc_alu_dmem.sv
// Self-checking bench for riscv_pc_alu_dmem (default build, ALU_EXT_OPS_EN undefined
// unless the same macro is given to the bench).

module tb_riscv_pc_alu_dmem;

    logic        clk;
    logic        reset;
    logic        finish_flag;
    logic [31:0] pc_reg;
    logic [3:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUout;
    logic        zero;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int          pass_count;
    int          total_count;
    logic [31:0] exp_q [$];
    logic [31:0] exp_v;
    logic [31:0] model_pc;
    logic [31:0] model_mem [int];

    riscv_pc_alu_dmem #(.DMEM_WORDS(256), .PC_STEP(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .finish_flag  (finish_flag),
        .pc_reg       (pc_reg),
        .ALUctl       (ALUctl),
        .A            (A),
        .B            (B),
        .ALUout       (ALUout),
        .zero         (zero),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .address      (address),
        .write_data   (write_data),
        .read_data    (read_data)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", pass_count, total_count);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] alu_model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        if (ctl == 4'd0) r = a & b;
        else if (ctl == 4'd1) r = a | b;
        else if (ctl == 4'd2) r = a + b;
        else if (ctl == 4'd6) r = a - b;
`ifdef ALU_EXT_OPS_EN
        else if (ctl == 4'd7) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else if (ctl == 4'd12) r = ~(a | b);
`endif
        return r;
    endfunction

    function automatic int mem_index(input logic [31:0] addr);
        return int'((addr >> 2) & 32'hFF);
    endfunction

    function automatic logic [31:0] mem_model_read(input logic [31:0] addr);
        int i;
        i = mem_index(addr);
        if (model_mem.exists(i)) return model_mem[i];
        return 32'h0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_q.push_back(32'h0);
        #2;
        exp_v = exp_q.pop_front();
        total_count++;
        if (pc_reg !== exp_v) $display("FAIL reset_async_pc: got %h expected %h", pc_reg, exp_v);
        else pass_count++;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(32'h0);
        exp_v = exp_q.pop_front();
        total_count++;
        if (pc_reg !== exp_v) $display("FAIL reset_hold_pc: got %h expected %h", pc_reg, exp_v);
        else pass_count++;
        model_pc = 32'h0;
    endtask

    task automatic test_pc_sequence();
        @(negedge clk);
        finish_flag = 1'b0;
        reset = 1'b1;
        exp_q.push_back(model_pc);
        #1;
        exp_v = exp_q.pop_front();
        total_count++;
        if (pc_reg !== exp_v) $display("FAIL pc_after_release: got %h expected %h", pc_reg, exp_v);
        else pass_count++;
        for (int i = 0; i < 3; i++) begin
            model_pc = model_pc + 32'd4;
            exp_q.push_back(model_pc);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (pc_reg !== exp_v) $display("FAIL pc_step_%0d: got %h expected %h", i, pc_reg, exp_v);
            else pass_count++;
        end
        finish_flag = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(32'd12);
            @(posedge clk);
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (pc_reg !== exp_v) $display("FAIL pc_frozen_%0d: got %h expected %h", i, pc_reg, exp_v);
            else pass_count++;
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        exp_q.push_back(32'd12);
        exp_v = exp_q.pop_front();
        total_count++;
        if (pc_reg !== exp_v) $display("FAIL pc_before_async: got %h expected %h", pc_reg, exp_v);
        else pass_count++;
        reset = 1'b0;
        ALUctl = 4'd2; A = 32'd5; B = 32'd7;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'd12);
        #1;
        exp_v = exp_q.pop_front();
        total_count++;
        if (pc_reg !== exp_v) $display("FAIL pc_async_clear: got %h expected %h", pc_reg, exp_v);
        else pass_count++;
        exp_v = exp_q.pop_front();
        total_count++;
        if (ALUout !== exp_v) $display("FAIL alu_during_reset: got %h expected %h", ALUout, exp_v);
        else pass_count++;
        finish_flag = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_pc = 32'h0;
        model_pc = model_pc + 32'd4;
        exp_q.push_back(model_pc);
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        total_count++;
        if (pc_reg !== exp_v) $display("FAIL pc_first_step: got %h expected %h", pc_reg, exp_v);
        else pass_count++;
    endtask

    task automatic test_alu();
        logic [3:0]  t_ctl [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd2, 4'd5};
        logic [31:0] t_a   [6] = '{32'd5, 32'd7, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'h1234};
        logic [31:0] t_b   [6] = '{32'd7, 32'd7, 32'hFF00, 32'hFF00, 32'd1, 32'h5678};
        logic [31:0] t_exp [6] = '{32'd12, 32'd0, 32'hF000, 32'hFFF0, 32'd0, 32'd0};
        logic [3:0]  ext_ctl [2] = '{4'd7, 4'd12};
        for (int i = 0; i < 6; i++) begin
            ALUctl = t_ctl[i]; A = t_a[i]; B = t_b[i];
            exp_q.push_back(t_exp[i]);
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (ALUout !== exp_v) $display("FAIL alu_vec_%0d: got %h expected %h", i, ALUout, exp_v);
            else pass_count++;
            total_count++;
            if (zero !== (exp_v == 32'h0)) $display("FAIL zero_vec_%0d: got %b expected %b", i, zero, (exp_v == 32'h0));
            else pass_count++;
        end
        for (int i = 0; i < 2; i++) begin
            ALUctl = ext_ctl[i]; A = 32'h8000_0000; B = 32'h0000_0001;
`ifdef ALU_EXT_OPS_EN
            exp_q.push_back((i == 0) ? 32'd1 : 32'h7FFF_FFFE);
`else
            exp_q.push_back(32'h0);
`endif
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (ALUout !== exp_v || zero !== (exp_v == 32'h0))
                $display("FAIL alu_ext_%0d: got %h/%b expected %h/%b", i, ALUout, zero, exp_v, (exp_v == 32'h0));
            else pass_count++;
        end
        for (int i = 0; i < 24; i++) begin
            ALUctl = 4'($urandom_range(0, 15));
            A = $urandom();
            B = (i % 4 == 0) ? A : $urandom();
            exp_q.push_back(alu_model(ALUctl, A, B));
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (ALUout !== exp_v || zero !== (exp_v == 32'h0))
                $display("FAIL alu_rand_%0d ctl=%0d: got %h/%b expected %h/%b", i, ALUctl, ALUout, zero, exp_v, (exp_v == 32'h0));
            else pass_count++;
        end
    endtask

    task automatic test_mem();
        logic [31:0] rd_addr [2] = '{32'd8, 32'd9};
        address = 32'h40; read_enable = 1'b1;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        total_count++;
        if (read_data !== exp_v) $display("FAIL mem_powerup_zero: got %h expected %h", read_data, exp_v);
        else pass_count++;
        read_enable = 1'b0;
        @(negedge clk);
        write_enable = 1'b1; address = 32'd8; write_data = 32'hDEADBEEF;
        @(posedge clk);
        model_mem[mem_index(32'd8)] = 32'hDEADBEEF;
        #1;
        write_enable = 1'b0;
        read_enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            address = rd_addr[i];
            exp_q.push_back(mem_model_read(rd_addr[i]));
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (read_data !== exp_v) $display("FAIL mem_load_%0d: got %h expected %h", i, read_data, exp_v);
            else pass_count++;
        end
        read_enable = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        total_count++;
        if (read_data !== exp_v) $display("FAIL mem_read_disabled: got %h expected %h", read_data, exp_v);
        else pass_count++;
    endtask

    task automatic test_mem_wrap();
        @(negedge clk);
        write_enable = 1'b1; address = 32'd1024; write_data = 32'h1234;
        @(posedge clk);
        model_mem[mem_index(32'd1024)] = 32'h1234;
        #1;
        write_enable = 1'b0;
        read_enable = 1'b1;
        address = 32'd0;
        exp_q.push_back(32'h1234);
        #1;
        exp_v = exp_q.pop_front();
        total_count++;
        if (read_data !== exp_v) $display("FAIL mem_wrap: got %h expected %h", read_data, exp_v);
        else pass_count++;
        read_enable = 1'b0;
    endtask

    task automatic test_reset_keeps_mem();
        @(negedge clk);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        read_enable = 1'b1;
        address = 32'd8;
        exp_q.push_back(mem_model_read(32'd8));
        #1;
        exp_v = exp_q.pop_front();
        total_count++;
        if (read_data !== exp_v) $display("FAIL mem_after_reset: got %h expected %h", read_data, exp_v);
        else pass_count++;
        read_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w_addr [4] = '{32'd16, 32'd20, 32'd16, 32'd1044};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            write_enable = 1'b1;
            read_enable = 1'b1;
            address = w_addr[i];
            write_data = 32'hA5A5_0000 + 32'(i);
            exp_q.push_back(mem_model_read(w_addr[i]));
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (read_data !== exp_v) $display("FAIL b2b_old_%0d: got %h expected %h", i, read_data, exp_v);
            else pass_count++;
            @(posedge clk);
            model_mem[mem_index(w_addr[i])] = write_data;
            exp_q.push_back(write_data);
            #1;
            exp_v = exp_q.pop_front();
            total_count++;
            if (read_data !== exp_v) $display("FAIL b2b_new_%0d: got %h expected %h", i, read_data, exp_v);
            else pass_count++;
        end
        @(negedge clk);
        write_enable = 1'b0;
        read_enable = 1'b0;
    endtask

    initial begin
        pass_count = 0;
        total_count = 0;
        finish_flag = 1'b0;
        ALUctl = 4'd0; A = 32'h0; B = 32'h0;
        write_enable = 1'b0; read_enable = 1'b0;
        address = 32'h0; write_data = 32'h0;
        model_pc = 32'h0;
        test_reset();
        test_pc_sequence();
        test_async_reset();
        test_alu();
        test_mem();
        test_mem_wrap();
        test_reset_keeps_mem();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
